// File: rtl/cps_layer_mixer.sv
// cps_layer_mixer -- per-pixel layer priority mixer behind the CPS-B line buffers.
//
// Each pixel strobe the sprite, scroll1, scroll2 and scroll3 pixels ({pal,pen})
// are resolved into one 11-bit palette RAM index {layer, pal, pen}. The order
// and enables come from LAYER_CTRL. Config registers are double-buffered: CPU
// writes land in a pending copy and FI copies pending to active at frame start.
//
// Optional feature macro: CPS_PRIO_MASK_EN adds PRIO_MASK0..3. A masked scroll
// pen placed below a winning sprite takes the pixel back from the sprite.
//
// Ports:
//   CLK_16M, RESET_N (async, active-low)  clock / reset
//   PIX_CE   pixel strobe; the two pipeline stages advance only on it
//   FI       frame start, pending -> active register copy
//   BLANK    blanking, travels with the pixel
//   CSB/WRB/CA/CDIN/CDOUT  68000 register port (CDOUT is combinational)
//   SPR_PIX, SC1_PIX, SC2_PIX, SC3_PIX  {pal[4:0], pen[3:0]}, pen F = transparent
//   SC1_GRP, SC2_GRP, SC3_GRP  scroll tile priority group (mask select)
//   PAL_IDX, PIX_VALID  resolved index, 2 strobes after the inputs

// One layer's stage-1 register: latches the pixel and its opacity.
module cps_mixer_lane (
  input  logic       CLK_16M,
  input  logic       RESET_N,
  input  logic       PIX_CE,
  input  logic [8:0] pix,
  output logic [8:0] s1_pix,
  output logic       s1_opq
);
  always_ff @(posedge CLK_16M or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_pix <= '0;
      s1_opq <= 1'b0;
    end else if (PIX_CE) begin
      s1_pix <= pix;
      s1_opq <= (pix[3:0] != 4'hF);
    end
  end
endmodule

module cps_layer_mixer #(
  parameter logic [4:0]  CTRL_ADDR = 5'h13,
  parameter logic [4:0]  MASK_ADDR = 5'h14,
  parameter logic [10:0] BACKDROP  = 11'h7FF
) (
  input  logic        CLK_16M,
  input  logic        RESET_N,
  input  logic        PIX_CE,
  input  logic        FI,
  input  logic        BLANK,
  input  logic        CSB,
  input  logic        WRB,
  input  logic [4:0]  CA,
  input  logic [15:0] CDIN,
  output logic [15:0] CDOUT,
  input  logic [8:0]  SPR_PIX,
  input  logic [8:0]  SC1_PIX,
  input  logic [8:0]  SC2_PIX,
  input  logic [8:0]  SC3_PIX,
  input  logic [1:0]  SC1_GRP,
  input  logic [1:0]  SC2_GRP,
  input  logic [1:0]  SC3_GRP,
  output logic [10:0] PAL_IDX,
  output logic        PIX_VALID
);
  localparam int          NUM_LANES = 4;
  localparam int          STAGES    = 2;
  localparam logic [15:0] CTRL_RST  = 16'h3E4F;

  // ---------------- stage 1: per-layer pixel/opacity registers ----------------
  logic [NUM_LANES-1:0][8:0] pix_in;
  logic [NUM_LANES-1:0][8:0] s1_pix;
  logic [NUM_LANES-1:0]      s1_opq;

  assign pix_in = {SC3_PIX, SC2_PIX, SC1_PIX, SPR_PIX};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cps_mixer_lane u_lane (
      .CLK_16M(CLK_16M),
      .RESET_N(RESET_N),
      .PIX_CE (PIX_CE),
      .pix    (pix_in[i]),
      .s1_pix (s1_pix[i]),
      .s1_opq (s1_opq[i])
    );
  end

  // Visibility rides alongside the pixel; reset clears it so the pipe
  // drains as blanked pixels.
  logic [STAGES:0] vld_pipe;
  assign vld_pipe[0] = ~BLANK;

  always_ff @(posedge CLK_16M or negedge RESET_N) begin
    if (!RESET_N)    vld_pipe[STAGES:1] <= '0;
    else if (PIX_CE) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // ---------------- config registers ----------------
  logic        cpu_wr;
  logic        cpu_rd;
  logic [15:0] ctrl_pend, ctrl_act;

  assign cpu_wr = !CSB && !WRB;
  assign cpu_rd = !CSB &&  WRB;

  // FI copies the pre-edge pending value, so a write on the FI edge
  // only shows up at the following frame.
  always_ff @(posedge CLK_16M or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl_pend <= CTRL_RST;
      ctrl_act  <= CTRL_RST;
    end else begin
      if (FI) ctrl_act <= ctrl_pend;
      if (cpu_wr && CA == CTRL_ADDR) ctrl_pend <= CDIN;
    end
  end

`ifdef CPS_PRIO_MASK_EN
  logic [3:0][15:0]          mask_pend, mask_act;
  logic [NUM_LANES-1:0][1:0] s1_grp;

  always_ff @(posedge CLK_16M or negedge RESET_N) begin
    if (!RESET_N) begin
      mask_pend <= '0;
      mask_act  <= '0;
    end else begin
      if (FI) mask_act <= mask_pend;
      for (int k = 0; k < 4; k++)
        if (cpu_wr && CA == MASK_ADDR + 5'(k)) mask_pend[k] <= CDIN;
    end
  end

  // Sprites have no group; lane 0 stays zero.
  always_ff @(posedge CLK_16M or negedge RESET_N) begin
    if (!RESET_N)    s1_grp <= '0;
    else if (PIX_CE) s1_grp <= {SC3_GRP, SC2_GRP, SC1_GRP, 2'b00};
  end
`else
  logic unused_grp;
  assign unused_grp = ^{SC1_GRP, SC2_GRP, SC3_GRP, MASK_ADDR};
`endif

  // ---------------- CPU readback (pending copy) ----------------
  always_comb begin
    CDOUT = 16'h0000;
    if (cpu_rd) begin
      if (CA == CTRL_ADDR) CDOUT = ctrl_pend;
`ifdef CPS_PRIO_MASK_EN
      for (int k = 0; k < 4; k++)
        if (CA == MASK_ADDR + 5'(k)) CDOUT = mask_pend[k];
`endif
    end
  end

  // ---------------- stage 2: resolution ----------------
  logic       win_found;
  logic [1:0] win_lyr;
  logic [1:0] win_slot;
  logic [1:0] scan_lyr;
`ifdef CPS_PRIO_MASK_EN
  logic       msk_hit;
`endif

  always_comb begin
    win_found = 1'b0;
    win_lyr   = 2'd0;
    win_slot  = 2'd0;
    scan_lyr  = 2'd0;
    // Top slot first; duplicate layer codes resolve at their topmost slot.
    for (int s = 3; s >= 0; s--) begin
      scan_lyr = ctrl_act[6+2*s +: 2];
      if (!win_found && ctrl_act[scan_lyr] && s1_opq[scan_lyr]) begin
        win_found = 1'b1;
        win_lyr   = scan_lyr;
        win_slot  = 2'(s);
      end
    end
`ifdef CPS_PRIO_MASK_EN
    msk_hit = 1'b0;
    // A sprite win can be overridden by a masked scroll pen lower down.
    if (win_found && win_lyr == 2'd0) begin
      for (int s = 2; s >= 0; s--) begin
        scan_lyr = ctrl_act[6+2*s +: 2];
        if (!msk_hit && s < int'(win_slot) && scan_lyr != 2'd0 &&
            ctrl_act[scan_lyr] && s1_opq[scan_lyr] &&
            mask_act[s1_grp[scan_lyr]][s1_pix[scan_lyr][3:0]]) begin
          msk_hit = 1'b1;
          win_lyr = scan_lyr;
        end
      end
    end
`endif
  end

  always_ff @(posedge CLK_16M or negedge RESET_N) begin
    if (!RESET_N)          PAL_IDX <= '0;
    else if (PIX_CE) begin
      if (!vld_pipe[1])    PAL_IDX <= '0;
      else if (win_found)  PAL_IDX <= {win_lyr, s1_pix[win_lyr]};
      else                 PAL_IDX <= BACKDROP;
    end
  end

  assign PIX_VALID = vld_pipe[STAGES];

endmodule

// File: tb/tb_cps_layer_mixer.sv
`timescale 1ns/1ps
module tb_cps_layer_mixer;
  logic        CLK_16M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        PIX_CE = 1'b0, FI = 1'b0, BLANK = 1'b0;
  logic        CSB = 1'b1, WRB = 1'b1;
  logic [4:0]  CA = '0;
  logic [15:0] CDIN = '0;
  logic [15:0] CDOUT;
  logic [8:0]  SPR_PIX = 9'h1FF, SC1_PIX = 9'h1FF, SC2_PIX = 9'h1FF, SC3_PIX = 9'h1FF;
  logic [1:0]  SC1_GRP = '0, SC2_GRP = '0, SC3_GRP = '0;
  logic [10:0] PAL_IDX;
  logic        PIX_VALID;

  cps_layer_mixer dut (
    .CLK_16M(CLK_16M), .RESET_N(RESET_N), .PIX_CE(PIX_CE), .FI(FI), .BLANK(BLANK),
    .CSB(CSB), .WRB(WRB), .CA(CA), .CDIN(CDIN), .CDOUT(CDOUT),
    .SPR_PIX(SPR_PIX), .SC1_PIX(SC1_PIX), .SC2_PIX(SC2_PIX), .SC3_PIX(SC3_PIX),
    .SC1_GRP(SC1_GRP), .SC2_GRP(SC2_GRP), .SC3_GRP(SC3_GRP),
    .PAL_IDX(PAL_IDX), .PIX_VALID(PIX_VALID)
  );

  always #31.25 CLK_16M = ~CLK_16M;

  localparam logic [4:0] A_CTRL = 5'h13;
  localparam logic [4:0] A_MASK = 5'h14;

  int total = 0;
  int bad   = 0;

  // Next pixel to present (index = layer code) and the model's view of it
  // once it sits in stage 1.
  logic [8:0]  cur_px[4];
  logic [1:0]  cur_grp[4];
  logic        cur_blk;
  logic [8:0]  s1_px[4];
  logic [1:0]  s1_grp[4];
  logic        s1_blk;
  logic [15:0] pend_ctrl, act_ctrl;
  logic [15:0] pend_mask[4], act_mask[4];

  logic [11:0] sb_q[$];
  logic [11:0] last_exp = '0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: walk the layer order from the top, take the first enabled
  // opaque layer; optionally let a masked scroll below a sprite win back.
  function automatic logic [11:0] resolve();
    int order[4];
    int pick;
    int pick_pos;
    if (s1_blk) return 12'h000;
    for (int k = 0; k < 4; k++) order[k] = int'(act_ctrl[12-2*k +: 2]); // order[0] = top
    pick = -1;
    pick_pos = 4;
    for (int k = 0; k < 4; k++)
      if (pick < 0 && act_ctrl[order[k]] && s1_px[order[k]][3:0] != 4'hF) begin
        pick = order[k];
        pick_pos = k;
      end
`ifdef CPS_PRIO_MASK_EN
    if (pick == 0) begin
      int alt;
      alt = -1;
      for (int k = pick_pos + 1; k < 4; k++)
        if (alt < 0 && order[k] != 0 && act_ctrl[order[k]] &&
            s1_px[order[k]][3:0] != 4'hF &&
            act_mask[s1_grp[order[k]]][s1_px[order[k]][3:0]])
          alt = order[k];
      if (alt >= 0) pick = alt;
    end
`endif
    if (pick < 0) return {1'b1, 11'h7FF};
    return {1'b1, 2'(pick), s1_px[pick]};
  endfunction

  function automatic logic [15:0] rd_exp(input logic [4:0] a);
    if (a == A_CTRL) return pend_ctrl;
`ifdef CPS_PRIO_MASK_EN
    if (a >= A_MASK && a <= A_MASK + 5'd3) return pend_mask[a - A_MASK];
`endif
    return 16'h0000;
  endfunction

  task automatic mdl_reset();
    pend_ctrl = 16'h3E4F;
    act_ctrl  = 16'h3E4F;
    for (int k = 0; k < 4; k++) begin
      pend_mask[k] = '0;
      act_mask[k]  = '0;
      s1_px[k]     = '0;
      s1_grp[k]    = '0;
    end
    s1_blk = 1'b1;
    sb_q.delete();
  endtask

  // One CLK_16M cycle of stimulus; the model tracks the same edge.
  task automatic cyc(input bit ce, input bit fi, input bit wr,
                     input logic [4:0] a, input logic [15:0] d);
    @(negedge CLK_16M);
    PIX_CE = ce; FI = fi; CSB = ~wr; WRB = ~wr; CA = a; CDIN = d;
    SPR_PIX = cur_px[0]; SC1_PIX = cur_px[1]; SC2_PIX = cur_px[2]; SC3_PIX = cur_px[3];
    SC1_GRP = cur_grp[1]; SC2_GRP = cur_grp[2]; SC3_GRP = cur_grp[3];
    BLANK = cur_blk;
    if (ce) begin
      sb_q.push_back(resolve());
      s1_px = cur_px; s1_grp = cur_grp; s1_blk = cur_blk;
    end
    if (fi) begin
      act_ctrl = pend_ctrl;
      act_mask = pend_mask;
    end
    if (wr) begin
      if (a == A_CTRL) pend_ctrl = d;
`ifdef CPS_PRIO_MASK_EN
      else if (a >= A_MASK && a <= A_MASK + 5'd3) pend_mask[a - A_MASK] = d;
`endif
    end
    @(posedge CLK_16M);
  endtask

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 5'h0, 16'h0);
      cyc(0, 0, 0, 5'h0, 16'h0);
    end
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [15:0] d);
    cyc(0, 0, 1, a, d);
  endtask

  task automatic pulse_fi();
    cyc(0, 1, 0, 5'h0, 16'h0);
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic cs_n);
    @(negedge CLK_16M);
    PIX_CE = 0; FI = 0; CSB = cs_n; WRB = 1'b1; CA = a;
    #1;
    check(nm, CDOUT, cs_n ? 16'h0000 : rd_exp(a));
    @(posedge CLK_16M);
  endtask

  task automatic set_px(input logic [8:0] s0, input logic [8:0] s1,
                        input logic [8:0] s2, input logic [8:0] s3);
    cur_px[0] = s0; cur_px[1] = s1; cur_px[2] = s2; cur_px[3] = s3;
  endtask

  function automatic logic [8:0] rnd_px();
    logic [3:0] pen;
    pen = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom_range(14));
    return {5'($urandom), pen};
  endfunction

  // Monitor: every strobe edge the DUT presents one pixel result.
  always @(posedge CLK_16M) begin
    if (PIX_CE && RESET_N) begin
      #1;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: got %h want none", {PIX_VALID, PAL_IDX});
      end else begin
        last_exp = sb_q.pop_front();
        if ({PIX_VALID, PAL_IDX} !== last_exp) begin
          bad++;
          $display("FAIL pixel: got %h want %h", {PIX_VALID, PAL_IDX}, last_exp);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) begin cur_px[k] = 9'h1FF; cur_grp[k] = 2'd0; end
    cur_blk = 1'b0;
    mdl_reset();

    // Reset state
    repeat (3) @(posedge CLK_16M);
    #1;
    check("rst_pal_idx", {5'h0, PAL_IDX}, 16'h0);
    check("rst_valid", {15'h0, PIX_VALID}, 16'h0);
    rd_chk("rst_ctrl_rd", A_CTRL, 1'b0);
    check("rst_ctrl_const", rd_exp(A_CTRL), 16'h3E4F);
    rd_chk("rd_unmapped", 5'h02, 1'b0);
    rd_chk("rd_csb_high", A_CTRL, 1'b1);
    rd_chk("rd_mask1", A_MASK + 5'd1, 1'b0);
    @(negedge CLK_16M);
    RESET_N = 1'b1;

    // Lone scroll3 pixel
    set_px(9'h1FF, 9'h1FF, 9'h1FF, 9'h025);
    strobe(3);

    // All opaque: default order has scroll3 on top
    set_px(9'h013, 9'h0A1, 9'h142, 9'h063);
    strobe(2);
    wr_reg(A_CTRL, 16'h0E4F);        // sprites moved to the top slot
    rd_chk("rd_ctrl_0e4f", A_CTRL, 1'b0);
    strobe(2);                       // no FI yet: still scroll3
    pulse_fi();
    strobe(3);

    // Backdrop and blanking
    set_px(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
    strobe(2);
    cur_blk = 1'b1;
    set_px(9'h013, 9'h0A1, 9'h142, 9'h063);
    strobe(3);
    cur_blk = 1'b0;

    // Write on the FI edge: pending only
    cyc(0, 1, 1, A_CTRL, 16'h390F);
    rd_chk("rd_ctrl_390f", A_CTRL, 1'b0);
    strobe(2);
    cyc(1, 1, 0, 5'h0, 16'h0);       // FI together with a strobe
    cyc(0, 0, 0, 5'h0, 16'h0);
    strobe(3);

`ifdef CPS_PRIO_MASK_EN
    wr_reg(A_CTRL, 16'h0E4F);
    wr_reg(A_MASK + 5'd1, 16'h0004);
    rd_chk("rd_mask1_val", A_MASK + 5'd1, 1'b0);
    pulse_fi();
    cur_grp[1] = 2'd1;
    set_px(9'h035, 9'h0C2, 9'h1FF, 9'h1FF);  // scroll1 pen 2 vs sprite pen 5
    strobe(2);
    set_px(9'h035, 9'h0C3, 9'h1FF, 9'h1FF);  // pen 3 not masked
    strobe(2);
`endif

    // Randomized traffic with config churn
    for (int it = 0; it < 400; it++) begin
      bit fi0, fi1, w0, w1;
      logic [4:0] a;
      for (int k = 0; k < 4; k++) begin
        cur_px[k]  = rnd_px();
        cur_grp[k] = 2'($urandom);
      end
      cur_blk = ($urandom_range(9) == 0);
      fi0 = ($urandom_range(7) == 0);
      fi1 = ($urandom_range(7) == 0);
      w0  = ($urandom_range(5) == 0);
      w1  = ($urandom_range(5) == 0);
      a   = ($urandom_range(1) == 0) ? A_CTRL : 5'(A_MASK + 5'($urandom_range(4)));
      cyc(1, fi0, w0, a, 16'($urandom));
      cyc(0, fi1, w1, A_CTRL, 16'($urandom));
      if (it % 50 == 0) rd_chk("rd_rand", a, 1'b0);
    end

    // Frozen outputs with PIX_CE low
    wr_reg(A_CTRL, 16'h3E4F);
    pulse_fi();
    set_px(9'h1FF, 9'h1FF, 9'h1FF, 9'h0B7);
    strobe(3);
    for (int i = 0; i < 5; i++) begin
      set_px(rnd_px(), rnd_px(), rnd_px(), rnd_px());
      cur_blk = ($urandom_range(1) == 0);
      cyc(0, 0, 0, 5'h0, 16'h0);
      #1;
      check("frozen", {4'h0, PIX_VALID, PAL_IDX}, {4'h0, last_exp});
    end
    cur_blk = 1'b0;

    // Mid-line asynchronous reset
    set_px(9'h1FF, 9'h1FF, 9'h1FF, 9'h0B7);
    strobe(3);
    check("pre_rst_visible", {4'h0, last_exp}, 16'h0EB7);
    @(negedge CLK_16M);
    RESET_N = 1'b0;
    #1;
    check("async_rst_idx", {5'h0, PAL_IDX}, 16'h0);
    check("async_rst_valid", {15'h0, PIX_VALID}, 16'h0);
    mdl_reset();
    rd_chk("rst_ctrl_again", A_CTRL, 1'b0);
    @(negedge CLK_16M);
    RESET_N = 1'b1;
    strobe(4);

    repeat (4) @(posedge CLK_16M);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
